// File: rtl/frame_pack_writer.sv
// Packs a 24-bit RGB pixel stream into 128-bit words of eight RGB565 pixels and writes them,
// with their frame-buffer word address, through a small FWFT FIFO to a valid/ready port.
module frame_pack_writer #(
  parameter int                    DATA_WIDTH = 24,
  parameter int                    OUT_WIDTH  = 128,
  parameter int                    H_PIXEL    = 960,
  parameter int                    V_PIXEL    = 540,
  parameter int                    ADDR_WIDTH = 28,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int                    FIFO_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  frame_i_vs,
  input  logic                  frame_i_hs,
  input  logic                  frame_i_valid,
  input  logic [DATA_WIDTH-1:0] frame_i_data,
  output logic                  wr_valid,
  input  logic                  wr_ready,
  output logic [OUT_WIDTH-1:0]  wr_data,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic                  wr_last,
  output logic                  frame_done,
  output logic                  overflow
);
  localparam int PIX_W   = $clog2(H_PIXEL + 1);
  localparam int LINE_W  = $clog2(V_PIXEL + 1);
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int ENTRY_W = OUT_WIDTH + ADDR_WIDTH + 2;
  localparam logic [PIX_W-1:0]      PIX_LAST  = PIX_W'(H_PIXEL - 1);
  localparam logic [LINE_W-1:0]     LINE_LAST = LINE_W'(V_PIXEL - 1);
  localparam logic [PTR_W:0]        DEPTH     = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] STRIDE    = ADDR_WIDTH'(H_PIXEL / 8);

  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

  state_t                  state, state_next;
  logic                    vs_d, hs_d, vs_rise, hs_rise;
  logic [PIX_W-1:0]        pix;
  logic [LINE_W-1:0]       line;
  logic [2:0]              lane;
  logic [7:0][15:0]        lanes, word_now;
  logic [15:0]             rgb565;
  logic [ADDR_WIDTH-1:0]   addr_now;
  logic                    pix_take, line_close, push_now, last_now, frame_end;
  logic                    push_q;
  logic [ENTRY_W-1:0]      push_entry, head;
  logic [ENTRY_W-1:0]      mem [FIFO_DEPTH];
  logic [PTR_W-1:0]        rd_ptr, wr_ptr;
  logic [PTR_W:0]          count;
  logic                    pop, fifo_write;
  logic                    unused_bits;

  assign vs_rise  = frame_i_vs & ~vs_d;
  assign hs_rise  = frame_i_hs & ~hs_d;
  assign lane     = pix[2:0];
  assign rgb565   = {frame_i_data[23:19], frame_i_data[15:10], frame_i_data[7:3]};
  assign addr_now = BASE_ADDR + ADDR_WIDTH'(line) * STRIDE + ADDR_WIDTH'(pix >> 3);
  assign unused_bits = ^{frame_i_data[18:16], frame_i_data[9:8], frame_i_data[2:0]};

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    pix_take   = 1'b0;
    line_close = 1'b0;
    state_next = state;
    if (state == ACTIVE && !vs_rise) begin
      line_close = hs_rise && (pix != '0);
      pix_take   = !hs_rise && frame_i_valid && (pix <= PIX_LAST);
    end
    push_now  = (pix_take && lane == 3'd7) || (line_close && lane != 3'd0);
    last_now  = line_close || (pix_take && pix == PIX_LAST);
    frame_end = (line == LINE_LAST) && ((pix_take && pix == PIX_LAST) || line_close);
    word_now  = lanes;
    if (pix_take) word_now[lane] = rgb565;
    if (vs_rise)        state_next = ACTIVE;
    else if (frame_end) state_next = DONE;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      vs_d       <= 1'b0;
      hs_d       <= 1'b0;
      pix        <= '0;
      line       <= '0;
      lanes      <= '0;
      push_q     <= 1'b0;
      push_entry <= '0;
    end else begin
      state  <= state_next;
      vs_d   <= frame_i_vs;
      hs_d   <= frame_i_hs;
      push_q <= push_now;
      if (push_now)
        push_entry <= {word_now, addr_now, last_now, last_now && (line == LINE_LAST)};
      if (vs_rise) begin
        pix   <= '0;
        line  <= '0;
        lanes <= '0;
      end else if (line_close) begin
        pix   <= '0;
        line  <= line + LINE_W'(1);
        lanes <= '0;
      end else if (pix_take) begin
        pix   <= pix + PIX_W'(1);
        lanes <= (lane == 3'd7) ? '0 : word_now;
      end
    end
  end

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign pop        = wr_valid && wr_ready;
  assign fifo_write = push_q && ((count != DEPTH) || pop);
  assign head       = mem[rd_ptr];

  // NOTE: FIFO storage is not reset; pointers and count alone define what is valid.
  always_ff @(posedge clk) begin
    if (fifo_write) mem[wr_ptr] <= push_entry;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (pop)        rd_ptr <= rd_ptr + PTR_W'(1);
      if (fifo_write) wr_ptr <= wr_ptr + PTR_W'(1);
      count      <= count + (PTR_W + 1)'(fifo_write) - (PTR_W + 1)'(pop);
      frame_done <= pop && head[0];
      if (vs_rise)                   overflow <= 1'b0;
      else if (push_q && !fifo_write) overflow <= 1'b1;
    end
  end

  // Outputs read as zero whenever nothing is queued.
  assign wr_valid = (count != '0);
  assign wr_data  = wr_valid ? head[ENTRY_W-1 -: OUT_WIDTH] : '0;
  assign wr_addr  = wr_valid ? head[ADDR_WIDTH+1:2] : '0;
  assign wr_last  = wr_valid && head[1];
endmodule

// File: tb/tb_frame_pack_writer.sv
// Self-checking bench for frame_pack_writer: a queue-based model of the packed word stream is
// compared with the DUT every cycle, plus hand-computed expectations per scenario.
module tb_frame_pack_writer;
  localparam int          H     = 16;
  localparam int          V     = 2;
  localparam int          DEPTH = 4;
  localparam logic [27:0] BASE  = 28'h100;

  logic         clk = 1'b0;
  logic         rst, frame_i_vs, frame_i_hs, frame_i_valid, wr_ready;
  logic [23:0]  frame_i_data;
  logic         wr_valid, wr_last, frame_done, overflow;
  logic [127:0] wr_data;
  logic [27:0]  wr_addr;

  always #5 clk = ~clk;

  frame_pack_writer #(
    .DATA_WIDTH(24), .OUT_WIDTH(128), .H_PIXEL(H), .V_PIXEL(V),
    .ADDR_WIDTH(28), .BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .frame_i_vs(frame_i_vs), .frame_i_hs(frame_i_hs),
    .frame_i_valid(frame_i_valid), .frame_i_data(frame_i_data),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .wr_addr(wr_addr), .wr_last(wr_last),
    .frame_done(frame_done), .overflow(overflow)
  );

  typedef struct {
    logic [127:0] data;
    logic [27:0]  addr;
    logic         last;
    logic         flast;
  } word_t;

  int n_checks = 0;
  int n_fail   = 0;
  int n_done   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model: pixels of the current line are kept as a list; words are formed from it.
  word_t       m_q[$];
  word_t       m_pend;
  bit          m_has_pend = 0;
  logic [15:0] m_pix[$];
  int          m_line = 0;
  bit          m_active = 0, m_prev_vs = 0, m_prev_hs = 0, m_ovf = 0, m_done = 0;

  function automatic logic [15:0] to565(input logic [23:0] d);
    return {d[23:19], d[15:10], d[7:3]};
  endfunction

  function automatic void emit(input bit last);
    int n, w;
    n = m_pix.size();
    w = (n - 1) / 8;
    m_pend.data = '0;
    for (int k = 0; k < 8; k++)
      if (w * 8 + k < n) m_pend.data[16*k +: 16] = m_pix[w * 8 + k];
    m_pend.addr  = BASE + 28'(m_line * (H / 8) + w);
    m_pend.last  = last;
    m_pend.flast = last && (m_line == V - 1);
    m_has_pend   = 1;
  endfunction

  task automatic model_step(input bit r, input bit v_s, input bit h_s, input bit vld,
                            input logic [23:0] d, input bit rdy);
    bit vs_r, hs_r, drop;
    vs_r = v_s && !m_prev_vs;
    hs_r = h_s && !m_prev_hs;
    m_prev_vs = v_s;
    m_prev_hs = h_s;
    m_done = 0;
    drop = 0;
    if (r) begin
      m_q.delete();
      m_pix.delete();
      m_has_pend = 0; m_active = 0; m_line = 0; m_ovf = 0;
      m_prev_vs = 0; m_prev_hs = 0;
      return;
    end
    if (m_q.size() > 0 && rdy) begin
      m_done = m_q[0].flast;
      m_q.delete(0);
    end
    if (m_has_pend) begin
      if (m_q.size() < DEPTH) m_q.push_back(m_pend);
      else drop = 1;
      m_has_pend = 0;
    end
    if (vs_r) begin
      m_ovf = 0; m_active = 1; m_line = 0;
      m_pix.delete();
    end else begin
      if (drop) m_ovf = 1;
      if (m_active) begin
        if (hs_r) begin
          if (m_pix.size() > 0) begin
            if (m_pix.size() % 8 != 0) emit(1);
            m_line++;
            m_pix.delete();
            if (m_line == V) m_active = 0;
          end
        end else if (vld && m_pix.size() < H) begin
          m_pix.push_back(to565(d));
          if (m_pix.size() % 8 == 0) begin
            emit(m_pix.size() == H);
            if (m_pix.size() == H && m_line == V - 1) m_active = 0;
          end
        end
      end
    end
  endtask

  // Compare process: inputs sampled at the edge, outputs checked 1 time unit later.
  word_t acc_q[$];
  word_t prev_word;
  bit    prev_valid = 0;

  always begin
    bit s_rst, s_vs, s_hs, s_vld, s_rdy;
    logic [23:0] s_d;
    @(posedge clk);
    s_rst = rst; s_vs = frame_i_vs; s_hs = frame_i_hs;
    s_vld = frame_i_valid; s_d = frame_i_data; s_rdy = wr_ready;
    if (!s_rst && prev_valid && s_rdy) acc_q.push_back(prev_word);
    model_step(s_rst, s_vs, s_hs, s_vld, s_d, s_rdy);
    #1;
    check("wr_valid", wr_valid, m_q.size() > 0);
    if (m_q.size() > 0) begin
      check("wr_data", wr_data, m_q[0].data);
      check("wr_addr", wr_addr, m_q[0].addr);
      check("wr_last", wr_last, m_q[0].last);
    end
    check("frame_done", frame_done, m_done);
    check("overflow", overflow, m_ovf);
    if (frame_done) n_done++;
    prev_valid     = wr_valid;
    prev_word.data = wr_data;
    prev_word.addr = wr_addr;
    prev_word.last = wr_last;
    prev_word.flast = 1'b0;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_vs();
    @(negedge clk) frame_i_vs = 1'b1;
    @(negedge clk) frame_i_vs = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_hs();
    @(negedge clk) frame_i_hs = 1'b1;
    @(negedge clk) frame_i_hs = 1'b0;
    @(negedge clk);
  endtask

  task automatic pixels(input int n, input logic [23:0] base, input int step);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      frame_i_valid = 1'b1;
      frame_i_data  = base + 24'(i * step);
    end
    @(negedge clk) frame_i_valid = 1'b0;
  endtask

  task automatic full_frame();
    for (int l = 0; l < V; l++) begin
      pulse_hs();
      pixels(H, 24'hFF0000, 1);
    end
  endtask

  task automatic clear_log();
    acc_q.delete();
    n_done = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] held;
    rst = 1'b1; frame_i_vs = 1'b0; frame_i_hs = 1'b0; frame_i_valid = 1'b0;
    frame_i_data = '0; wr_ready = 1'b1;
    tick(3);
    check("reset wr_valid", wr_valid, 0);
    check("reset wr_data", wr_data, 0);
    check("reset wr_addr", wr_addr, 0);
    check("reset wr_last", wr_last, 0);
    check("reset frame_done", frame_done, 0);
    check("reset overflow", overflow, 0);
    rst = 1'b0;
    tick(2);

    // Two full lines with the sink always ready.
    clear_log();
    pulse_vs();
    full_frame();
    tick(10);
    check("t1 words", acc_q.size(), 4);
    if (acc_q.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        check("t1 addr", acc_q[i].addr, BASE + 28'(i));
        check("t1 last", acc_q[i].last, (i % 2) == 1);
      end
      check("t1 data w0", acc_q[0].data, {8{16'hF800}});
      check("t1 data w1", acc_q[1].data, {8{16'hF801}});
    end
    check("t1 frame_done pulses", n_done, 1);
    check("t1 overflow", overflow, 0);

    // A one-pixel line flushed by hs, then the next line starts at its own stride.
    clear_log();
    pulse_vs();
    pulse_hs();
    pixels(1, 24'h123456, 0);
    pulse_hs();
    pixels(8, 24'h000000, 0);
    tick(6);
    check("t2 words", acc_q.size(), 2);
    if (acc_q.size() == 2) begin
      check("t2 data", acc_q[0].data, 128'h11AA);
      check("t2 last", acc_q[0].last, 1);
      check("t2 addr0", acc_q[0].addr, 28'h100);
      check("t2 addr1", acc_q[1].addr, 28'h102);
    end

    // Whole frame held by a stalled sink, then drained.
    clear_log();
    wr_ready = 1'b0;
    pulse_vs();
    full_frame();
    tick(5);
    check("t3 held valid", wr_valid, 1);
    check("t3 nothing accepted", acc_q.size(), 0);
    check("t3 overflow", overflow, 0);
    held = wr_data;
    tick(5);
    check("t3 data stable", wr_data, held);
    wr_ready = 1'b1;
    tick(10);
    check("t3 words", acc_q.size(), 4);
    if (acc_q.size() == 4)
      for (int i = 0; i < 4; i++) check("t3 addr order", acc_q[i].addr, BASE + 28'(i));
    check("t3 frame_done pulses", n_done, 1);

    // Second frame into a full FIFO: its words, including frame_last, are dropped.
    clear_log();
    wr_ready = 1'b0;
    pulse_vs();
    full_frame();
    pulse_vs();
    full_frame();
    tick(3);
    check("t4 overflow set", overflow, 1);
    wr_ready = 1'b1;
    tick(10);
    check("t4 overflow sticky", overflow, 1);
    check("t4 words", acc_q.size(), 4);
    check("t4 frame_done pulses", n_done, 1);
    pulse_vs();
    check("t4 overflow cleared", overflow, 0);

    // Restart mid-line discards the partial word.
    clear_log();
    pulse_hs();
    pixels(5, 24'hFFFFFF, 0);
    pulse_vs();
    pulse_hs();
    pixels(8, 24'h0000F8, 0);
    tick(6);
    check("t5 words", acc_q.size(), 1);
    if (acc_q.size() == 1) begin
      check("t5 addr", acc_q[0].addr, 28'h100);
      check("t5 data", acc_q[0].data, {8{16'h001F}});
      check("t5 last", acc_q[0].last, 0);
    end

    // Reset with two words queued and a partial line pending.
    clear_log();
    wr_ready = 1'b0;
    pulse_vs();
    pulse_hs();
    pixels(H, 24'h00FF00, 0);
    pulse_hs();
    pixels(3, 24'h00FF00, 0);
    tick(2);
    check("t6 queued before reset", wr_valid, 1);
    rst = 1'b1;
    tick(1);
    check("t6 wr_valid after reset", wr_valid, 0);
    check("t6 overflow after reset", overflow, 0);
    rst = 1'b0;
    wr_ready = 1'b1;
    pulse_hs();
    tick(10);
    check("t6 nothing emitted", acc_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
